data_mem_arbiter: RTL

// - Shares the single data-memory port (req/gnt/rvalid protocol) between NUM_REQ requesters.
// - Requester 0 is the core load/store unit; requester 1 is the debug/DMA port.
// - Round-robin arbitration, at most one outstanding transaction, and a registered owner.
//   The response is steered back to the requester that owns the transaction.
// - Sits between the MEM stage/LSU and the data memory.

---
 rtl/data_mem_arbiter_pkg.sv | 14 +
 rtl/data_mem_arbiter_if.sv | 47 ++++
 rtl/data_mem_arbiter_rr.sv | 33 +++
 rtl/data_mem_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter slice.
package data_mem_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WAIT_GNT = 2'd1,
        ARB_WAIT_RV  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side and memory-side bus of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface data_mem_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = data_mem_arbiter_pkg::DATA_WIDTH
);
    import data_mem_arbiter_pkg::*;

    // requester side
    logic [NUM_REQ-1:0]                 req_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ-1:0]                 we_i;
    logic [NUM_REQ-1:0][BE_WIDTH-1:0]   be_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]                 gnt_o;
    logic [NUM_REQ-1:0]                 rvalid_o;
    logic [DATA_WIDTH-1:0]              rdata_o;

    // memory side
    logic                               data_req_o;
    logic                               data_gnt_i;
    logic                               data_rvalid_i;
    logic [ADDR_WIDTH-1:0]              data_addr_o;
    logic                               data_we_o;
    logic [BE_WIDTH-1:0]                data_be_o;
    logic [DATA_WIDTH-1:0]              data_wdata_o;
    logic [DATA_WIDTH-1:0]              data_rdata_i;

    logic                               proto_err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  proto_err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output proto_err_o
    );

endinterface

// File: rtl/data_mem_arbiter_rr.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
module data_mem_arbiter_rr #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_win_oh_c,
    output logic [IW-1:0]      o_win_idx_c,
    output logic               o_valid_c
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        o_win_oh_c  = '0;
        o_win_idx_c = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_idx = IW'((32'(i_ptr) + off) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_win_idx_c        = w_idx;
                o_win_oh_c[w_idx]  = 1'b1;
            end
        end
        o_valid_c = w_found;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one req/gnt/rvalid data-memory port between NUM_REQ requesters.
// One transaction outstanding at a time; responses return to the owner.
module data_mem_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = data_mem_arbiter_pkg::DATA_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    data_mem_arbiter_if.slave bus
);
    import data_mem_arbiter_pkg::*;

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      w_owner_nxt;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      w_rr_ptr_nxt;

    logic [NUM_REQ-1:0] w_win_oh;
    logic [IW-1:0]      w_win_idx;
    logic               w_win_valid;

    logic               w_arb_en;
    logic               w_issue;
    logic [IW-1:0]      w_sel;
    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] w_rvalid;

    function automatic logic [IW-1:0] f_next_ptr(input logic [IW-1:0] i_idx);
        return (32'(i_idx) == NUM_REQ - 1) ? '0 : i_idx + IW'(1);
    endfunction

    data_mem_arbiter_rr #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req       (bus.req_i),
        .i_ptr       (r_rr_ptr),
        .o_win_oh_c  (w_win_oh),
        .o_win_idx_c (w_win_idx),
        .o_valid_c   (w_win_valid)
    );

    // Next state, owner/pointer updates, grant and response steering.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_arb_en     = 1'b0;
        w_issue      = 1'b0;
        w_sel        = r_owner;
        w_gnt        = '0;
        w_rvalid     = '0;

        case (r_state)
            ARB_IDLE: begin
                w_arb_en = 1'b1;
            end
            ARB_WAIT_GNT: begin
                // owner is locked; keep requesting even if it dropped req
                w_issue = 1'b1;
                if (bus.data_gnt_i) begin
                    w_gnt[r_owner] = 1'b1;
                    w_rr_ptr_nxt   = f_next_ptr(r_owner);
                    w_state_nxt    = ARB_WAIT_RV;
                end
            end
            ARB_WAIT_RV: begin
                if (bus.data_rvalid_i) begin
                    w_rvalid[r_owner] = 1'b1;
                    w_arb_en          = 1'b1;
                    w_state_nxt       = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase

        // New arbitration round (idle, or back-to-back behind a response).
        if (w_arb_en && w_win_valid) begin
            w_issue     = 1'b1;
            w_sel       = w_win_idx;
            w_owner_nxt = w_win_idx;
            if (bus.data_gnt_i) begin
                w_gnt        = w_win_oh;
                w_rr_ptr_nxt = f_next_ptr(w_win_idx);
                w_state_nxt  = ARB_WAIT_RV;
            end else begin
                w_state_nxt  = ARB_WAIT_GNT;
            end
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign bus.data_req_o   = w_issue;
    assign bus.data_addr_o  = w_issue ? bus.addr_i[w_sel]  : '0;
    assign bus.data_we_o    = w_issue ? bus.we_i[w_sel]    : 1'b0;
    assign bus.data_be_o    = w_issue ? bus.be_i[w_sel]    : '0;
    assign bus.data_wdata_o = w_issue ? bus.wdata_i[w_sel] : '0;
    assign bus.gnt_o        = w_gnt;
    assign bus.rvalid_o     = w_rvalid;
    assign bus.rdata_o      = bus.data_rdata_i;
    assign bus.proto_err_o  = bus.data_rvalid_i && (r_state != ARB_WAIT_RV);

endmodule
